if_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. Owns the program counter and drives the address/chip-enable pair into the combinational instruction ROM. Captures the returned word, with its PC, into the IF/ID pipeline register consumed by decode. Handles pipeline stall, branch redirect (with MIPS delay-slot semantics), exception flush, and a redirect that arrives while the stage is stalled.

---
 rtl/if_fetch_pkg.sv | 40 ++++
 rtl/if_id_reg.sv | 87 ++++++++
 rtl/if_fetch.sv | 192 +++++++++++++++++++
 tb/tb_if_fetch.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// ============================================================================
// if_fetch_pkg
// ----------------------------------------------------------------------------
// Shared constants and types for the instruction-fetch stage.
//   InstAddrWidth / InstDataWidth : instruction address / data bus widths
//   ZeroWord                      : all-zero word
//   ChipEnable / ChipDisable      : ROM chip-enable levels
//   NopInst                       : canonical MIPS NOP (sll $0,$0,0)
//   InstStep                      : byte distance between sequential fetches
//   pc_src_e                      : selects where the next PC comes from
//   pc_seq()                      : sequential PC increment, wraps at 2^32
// ============================================================================
package if_fetch_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstDataWidth = 32;

    localparam logic [InstDataWidth-1:0] ZeroWord    = 32'h0000_0000;
    localparam logic                     ChipEnable  = 1'b1;
    localparam logic                     ChipDisable = 1'b0;
    localparam logic [InstDataWidth-1:0] NopInst     = 32'h0000_0000;
    localparam logic [InstAddrWidth-1:0] InstStep    = 32'd4;

    // Source of the PC loaded on the next rising edge.
    typedef enum logic [2:0] {
        PC_SRC_HOLD   = 3'd0,
        PC_SRC_FLUSH  = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_REDIR  = 3'd3,
        PC_SRC_SEQ    = 3'd4
    } pc_src_e;

    // Plain modulo-2^32 add: 0xFFFF_FFFC rolls over to 0x0000_0000.
    function automatic logic [InstAddrWidth-1:0] pc_seq(
        input logic [InstAddrWidth-1:0] pc
    );
        return pc + InstStep;
    endfunction

endpackage : if_fetch_pkg

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg
// ----------------------------------------------------------------------------
// IF/ID pipeline register. Captures the fetched word and its PC for decode.
// Flush squashes the held instruction to NOP_INST (valid=0) regardless of
// stall; stall alone holds the contents; otherwise the fetch side is loaded.
//
// Optional feature macro: IF_FETCH_ALIGN_CHECK_EN adds the fetch-exception
// flag (fetch_excp -> id_excp).
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   stall        in   hold contents
//   flush        in   squash contents to NOP (wins over stall)
//   fetch_pc     in   PC of the word being fetched this cycle
//   fetch_inst   in   word being fetched this cycle
//   fetch_valid  in   fetched word is a real instruction
//   fetch_excp   in   fetch-address exception (macro only)
//   id_pc        out  held PC
//   id_inst      out  held instruction
//   id_valid     out  held instruction is real
//   id_excp      out  held fetch exception (macro only)
// ============================================================================
module if_id_reg
    import if_fetch_pkg::*;
#(
    parameter logic [InstDataWidth-1:0] NOP_INST = NopInst
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [InstAddrWidth-1:0] fetch_pc,
    input  logic [InstDataWidth-1:0] fetch_inst,
    input  logic                     fetch_valid,
`ifdef IF_FETCH_ALIGN_CHECK_EN
    input  logic                     fetch_excp,
    output logic                     id_excp,
`endif
    output logic [InstAddrWidth-1:0] id_pc,
    output logic [InstDataWidth-1:0] id_inst,
    output logic                     id_valid
);

    logic [InstAddrWidth-1:0] pc_reg;
    logic [InstDataWidth-1:0] inst_reg;
    logic                     valid_reg;

    // The PC field is kept on a flush: only the instruction and its valid
    // bit carry meaning for a squashed slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg    <= ZeroWord;
            inst_reg  <= NOP_INST;
            valid_reg <= 1'b0;
        end else if (flush) begin
            inst_reg  <= NOP_INST;
            valid_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg    <= fetch_pc;
            inst_reg  <= fetch_inst;
            valid_reg <= fetch_valid;
        end
    end

`ifdef IF_FETCH_ALIGN_CHECK_EN
    logic excp_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excp_reg <= 1'b0;
        end else if (flush) begin
            excp_reg <= 1'b0;
        end else if (!stall) begin
            excp_reg <= fetch_excp;
        end
    end

    assign id_excp = excp_reg;
`endif

    assign id_pc    = pc_reg;
    assign id_inst  = inst_reg;
    assign id_valid = valid_reg;

endmodule : if_id_reg

// File: rtl/if_fetch.sv
// ============================================================================
// if_fetch
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the MIPS pipeline. Owns the PC, drives the
// combinational instruction ROM, and fills the IF/ID register. Supports
// stall, taken branch with delay slot (the word fetched alongside the branch
// is passed on, not squashed), exception flush, and a branch that arrives
// while stalled (remembered and applied on the first unstalled edge).
//
// Optional feature macro: IF_FETCH_ALIGN_CHECK_EN. When defined, a PC with
// non-zero low bits is not sent to the ROM; IF/ID reports a fetch exception
// with the bad PC and the PC holds until a flush. When undefined the port
// id_excp_o does not exist and the low PC bits pass to the ROM unchanged.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-low reset
//   stall_i          in   hold PC and IF/ID
//   flush_i          in   exception flush: squash IF/ID, PC <= flush_pc_i
//   flush_pc_i       in   exception vector
//   branch_flag_i    in   taken branch/jump resolved in ID
//   branch_target_i  in   branch destination
//   rom_ce_o         out  ROM chip enable
//   rom_addr_o       out  ROM byte address (= PC)
//   rom_inst_i       in   ROM data, combinational from rom_addr_o
//   id_pc_o          out  PC of instruction in IF/ID
//   id_inst_o        out  instruction in IF/ID
//   id_valid_o       out  IF/ID holds a real fetched instruction
//   id_excp_o        out  fetch-address exception (macro only)
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrWidth-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [InstDataWidth-1:0] NOP_INST = NopInst
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic [InstAddrWidth-1:0] flush_pc_i,
    input  logic                     branch_flag_i,
    input  logic [InstAddrWidth-1:0] branch_target_i,
    output logic                     rom_ce_o,
    output logic [InstAddrWidth-1:0] rom_addr_o,
    input  logic [InstDataWidth-1:0] rom_inst_i,
    output logic [InstAddrWidth-1:0] id_pc_o,
    output logic [InstDataWidth-1:0] id_inst_o,
`ifdef IF_FETCH_ALIGN_CHECK_EN
    output logic                     id_excp_o,
`endif
    output logic                     id_valid_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                     ce_q;
    logic [InstAddrWidth-1:0] pc_q;
    logic [InstAddrWidth-1:0] pc_next;
    logic                     redir_pend_q;
    logic                     redir_pend_next;
    logic [InstAddrWidth-1:0] redir_tgt_q;
    logic [InstAddrWidth-1:0] redir_tgt_next;
    pc_src_e                  pc_src;

    // Fetch-side values presented to the IF/ID register.
    logic                     fetch_valid;
    logic [InstDataWidth-1:0] fetch_inst;

    // A misaligned PC freezes fetch; without the check it is simply never set.
    logic                     misaligned;

`ifdef IF_FETCH_ALIGN_CHECK_EN
    assign misaligned = ce_q && (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Fetch enable: comes up one edge after reset release and stays up.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q <= ChipDisable;
        end else begin
            ce_q <= ChipEnable;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC source selection (priority order).
    // ------------------------------------------------------------------
    always_comb begin
        pc_src = PC_SRC_HOLD;
        if (!ce_q) begin
            pc_src = PC_SRC_HOLD;
        end else if (flush_i) begin
            pc_src = PC_SRC_FLUSH;
        end else if (misaligned) begin
            // Bad fetch address: only a flush gets the stage moving again.
            pc_src = PC_SRC_HOLD;
        end else if (stall_i) begin
            pc_src = PC_SRC_HOLD;
        end else if (branch_flag_i) begin
            pc_src = PC_SRC_BRANCH;
        end else if (redir_pend_q) begin
            pc_src = PC_SRC_REDIR;
        end else begin
            pc_src = PC_SRC_SEQ;
        end
    end

    always_comb begin
        pc_next = pc_q;
        case (pc_src)
            PC_SRC_FLUSH:  pc_next = flush_pc_i;
            PC_SRC_BRANCH: pc_next = branch_target_i;
            PC_SRC_REDIR:  pc_next = redir_tgt_q;
            PC_SRC_SEQ:    pc_next = pc_seq(pc_q);
            default:       pc_next = pc_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Deferred redirect. A branch seen during a stall cannot move the PC
    // (the current word has not been captured yet), so it is parked here
    // and replayed on the first unstalled edge. A newer branch in the same
    // stall overwrites the older one. Any PC-changing event consumes it.
    // ------------------------------------------------------------------
    always_comb begin
        redir_pend_next = redir_pend_q;
        redir_tgt_next  = redir_tgt_q;
        if (ce_q) begin
            if (flush_i) begin
                redir_pend_next = 1'b0;
            end else if (misaligned) begin
                redir_pend_next = redir_pend_q;
            end else if (stall_i) begin
                if (branch_flag_i) begin
                    redir_pend_next = 1'b1;
                    redir_tgt_next  = branch_target_i;
                end
            end else if (branch_flag_i || redir_pend_q) begin
                redir_pend_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= ZeroWord;
        end else begin
            pc_q         <= pc_next;
            redir_pend_q <= redir_pend_next;
            redir_tgt_q  <= redir_tgt_next;
        end
    end

    // ------------------------------------------------------------------
    // ROM interface and fetch-side data.
    // ------------------------------------------------------------------
    assign rom_ce_o    = ce_q && !misaligned;
    assign rom_addr_o  = pc_q;
    assign fetch_valid = ce_q && !misaligned;
    assign fetch_inst  = fetch_valid ? rom_inst_i : NOP_INST;

    // ------------------------------------------------------------------
    // IF/ID pipeline register.
    // ------------------------------------------------------------------
    if_id_reg #(
        .NOP_INST    (NOP_INST)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall_i),
        .flush       (flush_i),
        .fetch_pc    (pc_q),
        .fetch_inst  (fetch_inst),
        .fetch_valid (fetch_valid),
`ifdef IF_FETCH_ALIGN_CHECK_EN
        .fetch_excp  (misaligned),
        .id_excp     (id_excp_o),
`endif
        .id_pc       (id_pc_o),
        .id_inst     (id_inst_o),
        .id_valid    (id_valid_o)
    );

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
// ============================================================================
// tb_if_fetch
// ----------------------------------------------------------------------------
// Self-checking bench for if_fetch. A small reference model of the fetch
// stage predicts the IF/ID contents for every clock; the prediction is queued
// when the inputs are driven and compared after the edge. Directed checks
// cover reset, delay slot, stalled redirect, flush during stall, PC wrap,
// asynchronous mid-run reset, and (with IF_FETCH_ALIGN_CHECK_EN) misaligned
// fetch. A short pseudo-random run follows.
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
`ifdef IF_FETCH_ALIGN_CHECK_EN
    logic        id_excp_o;
`endif

    always #5 clk = ~clk;

    // ROM contents: a fixed, address-dependent pattern never equal to NOP.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign rom_inst_i = rom_fn(rom_addr_o);

    if_fetch #(
        .RESET_PC        (32'h0000_0000),
        .NOP_INST        (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
`ifdef IF_FETCH_ALIGN_CHECK_EN
        .id_excp_o       (id_excp_o),
`endif
        .id_valid_o      (id_valid_o)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        excp;
        logic        chk_pc;
    } id_t;

    id_t         sb_q[$];
    id_t         m_id;
    logic        m_ce;
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;
    int          n_txn = 0;

    task automatic model_reset();
        m_ce   = 1'b0;
        m_pc   = 32'h0;
        m_pend = 1'b0;
        m_tgt  = 32'h0;
        m_id   = '{pc: 32'h0, inst: NOP, valid: 1'b0, excp: 1'b0, chk_pc: 1'b1};
    endtask

    // One clock: called and returning at a falling edge.
    task automatic cycle(input logic st, input logic fl, input logic [31:0] fpc,
                         input logic br, input logic [31:0] bt);
        id_t  e;
        id_t  got;
        logic mis;
`ifdef IF_FETCH_ALIGN_CHECK_EN
        mis = m_ce && (m_pc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        check_eq("rom_ce", {31'b0, rom_ce_o}, {31'b0, m_ce && !mis});
        check_eq("rom_addr", rom_addr_o, m_pc);

        // Predicted IF/ID after this edge.
        if (fl) begin
            e = '{pc: m_id.pc, inst: NOP, valid: 1'b0, excp: 1'b0, chk_pc: 1'b0};
        end else if (st) begin
            e = m_id;
        end else if (!m_ce) begin
            e = '{pc: m_pc, inst: NOP, valid: 1'b0, excp: 1'b0, chk_pc: 1'b0};
        end else if (mis) begin
            e = '{pc: m_pc, inst: NOP, valid: 1'b0, excp: 1'b1, chk_pc: 1'b1};
        end else begin
            e = '{pc: m_pc, inst: rom_fn(m_pc), valid: 1'b1, excp: 1'b0, chk_pc: 1'b1};
        end
        m_id = e;
        sb_q.push_back(e);

        // Predicted PC / pending redirect.
        if (!m_ce) begin
            m_ce = 1'b1;
        end else if (fl) begin
            m_pc   = fpc;
            m_pend = 1'b0;
        end else if (mis) begin
            m_pc = m_pc;
        end else if (st) begin
            if (br) begin
                m_pend = 1'b1;
                m_tgt  = bt;
            end
        end else if (br) begin
            m_pc   = bt;
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc   = m_tgt;
            m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end

        stall_i         = st;
        flush_i         = fl;
        flush_pc_i      = fpc;
        branch_flag_i   = br;
        branch_target_i = bt;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        n_txn++;
        $display("txn %0d: st=%b fl=%b br=%b id_pc=%08h id_inst=%08h id_valid=%b",
                 n_txn, st, fl, br, id_pc_o, id_inst_o, id_valid_o);
        check_eq("id_valid", {31'b0, id_valid_o}, {31'b0, got.valid});
        check_eq("id_inst", id_inst_o, got.inst);
        if (got.chk_pc) check_eq("id_pc", id_pc_o, got.pc);
`ifdef IF_FETCH_ALIGN_CHECK_EN
        check_eq("id_excp", {31'b0, id_excp_o}, {31'b0, got.excp});
`endif
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst             = 1'b0;
        stall_i         = 1'b0;
        flush_i         = 1'b0;
        flush_pc_i      = 32'h0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state.
        check_eq("rst_rom_ce", {31'b0, rom_ce_o}, 32'h0);
        check_eq("rst_rom_addr", rom_addr_o, 32'h0);
        check_eq("rst_id_pc", id_pc_o, 32'h0);
        check_eq("rst_id_inst", id_inst_o, NOP);
        check_eq("rst_id_valid", {31'b0, id_valid_o}, 32'h0);

        // Release: fetch addresses 0, 0, 4, 8.
        rst = 1'b1;
        check_eq("seq_addr0", rom_addr_o, 32'h0);
        idle(1);
        check_eq("seq_addr1", rom_addr_o, 32'h0);
        check_eq("seq_valid1", {31'b0, id_valid_o}, 32'h0);
        idle(1);
        check_eq("seq_addr2", rom_addr_o, 32'h4);
        check_eq("first_valid", {31'b0, id_valid_o}, 32'h1);
        check_eq("first_pc", id_pc_o, 32'h0);
        idle(1);
        check_eq("seq_addr3", rom_addr_o, 32'h8);
        idle(2);

        // Branch to 0x100 while PC = 0x10: 0x10 is the delay slot.
        check_eq("pre_br_addr", rom_addr_o, 32'h10);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        check_eq("dslot_pc", id_pc_o, 32'h10);
        check_eq("br_addr", rom_addr_o, 32'h100);
        idle(1);
        check_eq("br_id_pc", id_pc_o, 32'h100);
        idle(1);

        // Three-cycle stall, branch to 0x200 in the middle cycle.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("stall_hold_addr", rom_addr_o, 32'h108);
        check_eq("stall_hold_pc", id_pc_o, 32'h104);
        idle(1);
        check_eq("unstall_id_pc", id_pc_o, 32'h108);
        check_eq("redir_addr", rom_addr_o, 32'h200);
        idle(2);

        // Flush to 0x180 during a stall with a redirect pending.
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
        cycle(1'b1, 1'b1, 32'h180, 1'b0, 32'h0);
        check_eq("flush_valid", {31'b0, id_valid_o}, 32'h0);
        check_eq("flush_inst", id_inst_o, NOP);
        check_eq("flush_addr", rom_addr_o, 32'h180);
        idle(1);
        check_eq("drop_pend_addr", rom_addr_o, 32'h184);
        idle(1);

        // Wrap at the top of the address space.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        check_eq("wrap_pre", rom_addr_o, 32'hFFFF_FFFC);
        idle(1);
        check_eq("wrap_addr", rom_addr_o, 32'h0);
        idle(2);

`ifdef IF_FETCH_ALIGN_CHECK_EN
        // Misaligned branch target: fetch freezes until a flush.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
        check_eq("mis_rom_ce", {31'b0, rom_ce_o}, 32'h0);
        idle(1);
        check_eq("mis_excp", {31'b0, id_excp_o}, 32'h1);
        check_eq("mis_id_pc", id_pc_o, 32'h102);
        idle(2);
        check_eq("mis_hold", rom_addr_o, 32'h102);
        cycle(1'b0, 1'b1, 32'h180, 1'b0, 32'h0);
        check_eq("mis_resume", rom_addr_o, 32'h180);
        idle(2);
`endif

        // Asynchronous reset in mid-run (between edges).
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h440);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_rom_ce", {31'b0, rom_ce_o}, 32'h0);
        check_eq("arst_addr", rom_addr_o, 32'h0);
        check_eq("arst_valid", {31'b0, id_valid_o}, 32'h0);
        check_eq("arst_inst", id_inst_o, NOP);
        model_reset();
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        check_eq("arst_no_pend", rom_addr_o, 32'hC);

        // Pseudo-random traffic with word-aligned targets.
        for (int i = 0; i < 60; i++) begin
            logic st, fl, br;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 11) == 0);
            br = ($urandom_range(0, 4) == 0);
            cycle(st, fl, {$urandom_range(0, 255), 2'b00} + 32'h800, br,
                  {$urandom_range(0, 1023), 2'b00});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net: the run is bounded in time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_if_fetch
